// File: rtl/cfg_bitstream_loader_if.sv
// Host-side byte stream feeding the configuration loader (valid/ready handshake).
interface cfg_bitstream_loader_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/cfg_bitstream_loader.sv
// Serialises host configuration bytes (LSB first) into cfg_value/cfg_clk pulses
// that shift exactly CHAIN_LEN bits through the fabric configuration chain.
module cfg_bitstream_loader #(
    parameter int unsigned CHAIN_LEN = 5,
    parameter int unsigned CLK_DIV   = 2,
    localparam int unsigned CNT_W    = $clog2(CHAIN_LEN + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    cfg_bitstream_loader_if.slave  host_if,
    output logic                   cfg_clk_o,
    output logic                   cfg_value_o,
    output logic                   busy_o,
    output logic                   loaded_o,
    output logic [CNT_W-1:0]       bit_count_o
);

    localparam int unsigned      DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_FINAL = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_SETUP,
        S_HIGH,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cfg_clk_q, cfg_clk_d;
    logic               value_q, value_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               loaded_q, loaded_d;

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            div_q     <= '0;
            cnt_q     <= '0;
            cfg_clk_q <= 1'b0;
            value_q   <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            loaded_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            cfg_clk_q <= cfg_clk_d;
            value_q   <= value_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            loaded_q  <= loaded_d;
        end
    end

    // Next state; outputs are precomputed from the next state so they stay glitch-free
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        value_d   = value_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_WAIT_BYTE;
                    cnt_d   = '0;
                end
            end
            S_WAIT_BYTE: begin
                if (host_if.valid && ready_q) begin
                    shift_d   = host_if.data;
                    bit_idx_d = 3'd0;
                    div_d     = '0;
                    value_d   = host_if.data[0];
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_HIGH;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_HIGH: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q == CNT_FINAL) begin
                        state_d = S_DONE;
                    end else if (bit_idx_q == 3'd7) begin
                        state_d = S_WAIT_BYTE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        value_d   = shift_q[bit_idx_d];
                        state_d   = S_SETUP;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        cfg_clk_d = (state_d == S_HIGH);
        ready_d   = (state_d == S_WAIT_BYTE);
        busy_d    = (state_d == S_WAIT_BYTE) || (state_d == S_SETUP) || (state_d == S_HIGH);
        loaded_d  = (state_d == S_DONE);
    end

    assign host_if.ready = ready_q;
    assign cfg_clk_o     = cfg_clk_q;
    assign cfg_value_o   = value_q;
    assign busy_o        = busy_q;
    assign loaded_o      = loaded_q;
    assign bit_count_o   = cnt_q;

endmodule

// File: doc/cfg_bitstream_loader.md
Name: cfg_bitstream_loader

Overview:
- Upstream driver for the fabric configuration chain.
- Accepts configuration bytes from a host-side byte stream over a valid/ready handshake.
- Serialises the bytes into cfg_value / cfg_clk pulses that shift the bits through the chain of cfg_bit cells in a cell array.
- Shifts exactly CHAIN_LEN bits per load, then reports completion so the fabric clock can be released.

Parameters:
- CHAIN_LEN, 5: total config bits in the chain (5 = one cell); must be ≥1.
- CLK_DIV, 2: clk_i cycles per cfg_clk phase (low and high each); must be ≥1.

Ports:
- clk_i, input, 1: system clock.
- rst_n_i, input, 1: asynchronous active-low reset.
- start_i, input, 1: begin a new load; sampled only in IDLE or DONE.
- data_i, input, 8: configuration byte, consumed LSB first.
- valid_i, input, 1: data_i valid.
- ready_o, output, 1: loader can accept a byte.
- cfg_clk_o, output, 1: chain shift clock, registered and glitch-free.
- cfg_value_o, output, 1: chain serial data.
- busy_o, output, 1: load in progress (WAIT_BYTE, SETUP or HIGH).
- loaded_o, output, 1: full chain shifted, no load since.
- bit_count_o, output, clog2(CHAIN_LEN+1): bits shifted in the current load.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - cfg_clk_o, cfg_value_o, ready_o, busy_o, loaded_o all 0; bit_count_o = 0.
  - Chain contents are undefined after a mid-load reset.
- All outputs are registered or decoded from state; there is no combinational path from valid_i to cfg_*.
- IDLE / DONE:
  - start_i = 1 → WAIT_BYTE, bit_count cleared, loaded_o cleared next cycle.
  - DONE holds loaded_o = 1 until start_i.
  - In IDLE and DONE, ready_o = 0 and valid_i is ignored.
- WAIT_BYTE:
  - ready_o = 1, cfg_clk_o = 0.
  - On valid_i && ready_o: latch data_i into shift_reg, bit_idx = 0 → SETUP.
  - valid_i low stalls indefinitely with cfg_clk_o held low.
- SETUP:
  - cfg_clk_o = 0, cfg_value_o = shift_reg[bit_idx].
  - Lasts CLK_DIV cycles → HIGH.
  - cfg_value_o changes only on entry to SETUP, which guarantees ≥CLK_DIV cycles of setup before the rising edge.
- HIGH:
  - cfg_clk_o = 1, cfg_value_o held; lasts CLK_DIV cycles.
  - On the last cycle, bit_count increments. Then:
    - new count == CHAIN_LEN → DONE;
    - else bit_idx == 7 → WAIT_BYTE;
    - else bit_idx + 1 → SETUP.
- Timing:
  - One bit = 2·CLK_DIV cycles.
  - Byte handshake in cycle t → cfg_value_o valid at t+1 → cfg_clk_o rises at t+1+CLK_DIV.
  - Exactly one rising cfg_clk_o edge per shifted bit.
- Bit order:
  - Bytes are consumed in arrival order, LSB first; the bit stream is the concatenation.
  - The first bit shifted ends at the far end of the chain.
  - For a single cell, stream order is register, on11, on10, on01, on00.
- Last byte: when CHAIN_LEN is not a multiple of 8, unused upper bits of the final byte are discarded. ready_o is not reasserted, so no extra byte is consumed.
- start_i while busy_o = 1 is ignored; the load continues.
- cfg_value_o retains its last value in WAIT_BYTE and DONE. cfg_clk_o is 0 in every state except HIGH.
- bit_count_o saturates at CHAIN_LEN and never wraps.

Test Plan:
1. Single-cell load, CHAIN_LEN=5, CLK_DIV=2. start_i pulse at cycle 0; byte 0x15 offered from cycle 1.
   - Handshake occurs at cycle 1.
   - 5 rising edges of cfg_clk_o at cycles 4, 8, 12, 16, 20.
   - cfg_value_o at those edges = 1, 0, 1, 0, 1.
   - loaded_o = 1 from cycle 22; ready_o never reasserts.
2. Multi-byte load, CHAIN_LEN=10, bytes 0xFF then 0x02.
   - ready_o rises once, after the 8th HIGH phase.
   - 10 edges carrying 1×8, then 0, 1.
   - bit_count_o = 10; the second byte's bits 2–7 are never driven.
3. Backpressure: withhold valid_i for 50 cycles after the first byte of scenario 2.
   - cfg_clk_o stays 0 and busy_o stays 1 throughout.
   - Resumes correctly with identical edge sequence after the stall.
4. Reset mid-HIGH during bit 3 of scenario 1.
   - cfg_clk_o drops to 0 in the same cycle, without waiting for clk_i.
   - All outputs reach reset values.
   - A fresh start_i then loads correctly.
5. start_i pulsed during SETUP of bit 2: edge count and values are unchanged from scenario 1.
6. End-to-end with one cell (CLK_DIV=1, byte 0x02 → AND LUT, combinational).
   - After loaded_o, drive x,y = 00 / 01 / 10 / 11; cell output = 0 / 0 / 0 / 1.
